// File: rtl/cnn_batch_sched_if.sv
// ----------------------------------------------------------------------------
// cnn_batch_sched_if
// Bundles the batch-side, core-side and status signals of cnn_batch_sched.
//
// Signals (names as seen by the scheduler):
//   i_in_valid / o_in_ready / i_in_fmap   : batch handshake, NB images packed,
//                                           image k at [k*IMG_W +: IMG_W]
//   o_core_valid / o_core_fmap            : one-cycle load pulse + image to core
//   i_core_valid / i_core_fmap            : result returned by the core
//   o_ot_valid / o_ot_fmap                : batch-complete pulse + NB results,
//                                           slot k at [k*OT_W +: OT_W]
//   o_busy / o_error                      : status (busy = not idle,
//                                           error = sticky timeout flag)
//
// Modports:
//   slave  : the scheduler itself
//   master : the environment (upstream source + core + result sink)
// ----------------------------------------------------------------------------
interface cnn_batch_sched_if #(
    parameter int NB    = 2,
    parameter int IMG_W = 8*3*5*5,
    parameter int OT_W  = 8*3*3*3
);
    logic                  i_in_valid;
    logic                  o_in_ready;
    logic [NB*IMG_W-1:0]   i_in_fmap;
    logic                  o_core_valid;
    logic [IMG_W-1:0]      o_core_fmap;
    logic                  i_core_valid;
    logic [OT_W-1:0]       i_core_fmap;
    logic                  o_ot_valid;
    logic [NB*OT_W-1:0]    o_ot_fmap;
    logic                  o_busy;
    logic                  o_error;

    modport slave (
        input  i_in_valid, i_in_fmap, i_core_valid, i_core_fmap,
        output o_in_ready, o_core_valid, o_core_fmap, o_ot_valid, o_ot_fmap,
               o_busy, o_error
    );

    modport master (
        output i_in_valid, i_in_fmap, i_core_valid, i_core_fmap,
        input  o_in_ready, o_core_valid, o_core_fmap, o_ot_valid, o_ot_fmap,
               o_busy, o_error
    );
endinterface

// File: rtl/cnn_batch_sched.sv
// ----------------------------------------------------------------------------
// cnn_batch_sched
// Accepts a batch of NB input feature maps, feeds them one at a time to a
// single cnn_core, collects the NB results and presents them together with a
// one-cycle batch-complete pulse.
//
// Ports:
//   clk          : clock, rising edge
//   reset_n      : asynchronous active-low reset
//   i_soft_reset : synchronous active-high clear, highest priority
//   bus          : cnn_batch_sched_if.slave (batch in, core load/return,
//                  batch out, busy/error status)
//
// Optional feature: define CNN_SCHED_TIMEOUT_EN to bound every WAIT to
// TIMEOUT cycles; on expiry the batch is dropped and o_error is set (sticky
// until reset). Without the macro WAIT waits forever and o_error is 0.
// ----------------------------------------------------------------------------
module cnn_batch_sched #(
    parameter int NB      = 2,
    parameter int IMG_W   = 8*3*5*5,
    parameter int OT_W    = 8*3*3*3,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_soft_reset,
    cnn_batch_sched_if.slave       bus
);

    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

    if (NB < 1 || TIMEOUT < 1) begin : g_param_err
        $error("cnn_batch_sched: NB and TIMEOUT must both be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [IDX_W-1:0]      idx_q;
    logic [NB*IMG_W-1:0]   batch_q;
    logic [IMG_W-1:0]      core_fmap_q;
    logic [NB*OT_W-1:0]    res_buf_q;
    logic [NB*OT_W-1:0]    res_buf_d;
    logic [NB*OT_W-1:0]    ot_fmap_q;
    logic [IMG_W-1:0]      next_img;
    logic                  accept;
    logic                  res_wr;
    logic                  last_img;

    assign accept   = (state_q == IDLE) && bus.i_in_valid;
    assign res_wr   = (state_q == WAIT) && bus.i_core_valid;
    assign last_img = (idx_q == IDX_W'(NB - 1));

`ifdef CNN_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] tmo_cnt_q;
    logic             error_q;
    logic             tmo_hit;

    // The TIMEOUT-th silent WAIT cycle is the last one allowed.
    assign tmo_hit = (state_q == WAIT) && !bus.i_core_valid &&
                     (tmo_cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_q <= '0;
            error_q   <= 1'b0;
        end else if (i_soft_reset) begin
            tmo_cnt_q <= '0;
            error_q   <= 1'b0;
        end else begin
            if (state_q == ISSUE) begin
                tmo_cnt_q <= '0;
            end else if ((state_q == WAIT) && !bus.i_core_valid) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
            if (tmo_hit) begin
                error_q <= 1'b1;
            end
        end
    end

    assign bus.o_error = error_q;
`else
    assign bus.o_error = 1'b0;
`endif

    // ---- state register ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else if (i_soft_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.i_in_valid) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.i_core_valid) begin
                    state_d = last_img ? DONE : ISSUE;
                end
`ifdef CNN_SCHED_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d = IDLE;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Result buffer with the returning core result merged into slot idx.
    // The same merged value feeds o_ot_fmap on the final write so the
    // output register is updated once per batch, on entry to DONE.
    always_comb begin
        res_buf_d = res_buf_q;
        res_buf_d[int'(idx_q)*OT_W +: OT_W] = bus.i_core_fmap;
    end

    // Image for the following ISSUE; only used when idx is not the last slot.
    always_comb begin
        next_img = core_fmap_q;
        if (!last_img) begin
            next_img = batch_q[(int'(idx_q) + 1)*IMG_W +: IMG_W];
        end
    end

    // ---- batch capture, image issue and result collection ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q       <= '0;
            batch_q     <= '0;
            core_fmap_q <= '0;
            res_buf_q   <= '0;
            ot_fmap_q   <= '0;
        end else if (i_soft_reset) begin
            idx_q       <= '0;
            batch_q     <= '0;
            core_fmap_q <= '0;
            res_buf_q   <= '0;
            ot_fmap_q   <= '0;
        end else begin
            if (accept) begin
                batch_q     <= bus.i_in_fmap;
                idx_q       <= '0;
                core_fmap_q <= bus.i_in_fmap[IMG_W-1:0];
            end
            if (res_wr) begin
                res_buf_q <= res_buf_d;
                if (last_img) begin
                    ot_fmap_q <= res_buf_d;
                end else begin
                    idx_q       <= idx_q + 1'b1;
                    core_fmap_q <= next_img;
                end
            end
        end
    end

    // Ready is masked while reset_n is low so every output reads 0 during
    // an asynchronous reset.
    assign bus.o_in_ready   = reset_n && (state_q == IDLE);
    assign bus.o_core_valid = (state_q == ISSUE);
    assign bus.o_core_fmap  = core_fmap_q;
    assign bus.o_ot_valid   = (state_q == DONE);
    assign bus.o_ot_fmap    = ot_fmap_q;
    assign bus.o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_cnn_batch_sched.sv
module tb_cnn_batch_sched;
    localparam int NB    = 2;
    localparam int IMG_W = 8*3*5*5;
    localparam int OT_W  = 8*3*3*3;
    localparam int CW    = NB*IMG_W;
`ifdef CNN_SCHED_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic i_soft_reset = 1'b0;

    always #5 clk = ~clk;

    cnn_batch_sched_if #(.NB(NB), .IMG_W(IMG_W), .OT_W(OT_W)) bus ();

    cnn_batch_sched #(.NB(NB), .IMG_W(IMG_W), .OT_W(OT_W), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_soft_reset (i_soft_reset),
        .bus          (bus)
    );

    int checks = 0;
    int passes = 0;

    logic [IMG_W-1:0]   img_q[$];
    logic [NB*OT_W-1:0] res_q[$];
    logic [NB*OT_W-1:0] last_ot = '0;

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h (low 48 bits, %0d differing bits)",
                    tag, obs[47:0], exp[47:0], $countones(obs ^ exp));
    endtask

    task automatic fail_now(input string tag);
        checks++;
        $error("FAIL %s: observed no event expected event within budget", tag);
    endtask

    // Core model: result is a fixed scramble of the image it was given.
    function automatic logic [OT_W-1:0] res_of(input logic [IMG_W-1:0] img);
        logic [OT_W-1:0] m;
        m = {(OT_W/8){8'h5A}};
        return img[OT_W-1:0] ^ m;
    endfunction

    function automatic logic [IMG_W-1:0] mk_img(input logic [31:0] s);
        logic [19*32-1:0] t;
        t = {19{s}};
        return t[IMG_W-1:0];
    endfunction

    // One batch: accept in cycle 0, core answers in the lat-th WAIT cycle.
    task automatic run_batch(input logic [IMG_W-1:0] a, input logic [IMG_W-1:0] b,
                             input int lat, input bit hold, input bit spur);
        int pend;
        int issue_n;
        bit seen;
        logic [IMG_W-1:0] cur;
        logic [NB*OT_W-1:0] exp_ot;
        pend = 0; issue_n = 0; seen = 0; cur = '0;
        @(negedge clk);
        chk("in_ready_accept", bus.o_in_ready, 1'b1);
        bus.i_in_valid = 1'b1;
        bus.i_in_fmap  = {b, a};
        img_q.push_back(a);
        img_q.push_back(b);
        res_q.push_back({res_of(b), res_of(a)});
        for (int cyc = 1; cyc <= 60 && !seen; cyc++) begin
            @(negedge clk);
            bus.i_core_valid = 1'b0;
            bus.i_core_fmap  = '0;
            if (!hold) bus.i_in_valid = 1'b0;
            chk("in_ready_busy", bus.o_in_ready, 1'b0);
            if (bus.o_core_valid) begin
                chk("issue_cycle", cyc, issue_n*(lat+1)+1);
                if (img_q.size() == 0) fail_now("img_queue_empty");
                else cur = img_q.pop_front();
                chk("core_fmap_issue", bus.o_core_fmap, cur);
                issue_n++;
                pend = lat;
                if (spur) begin
                    bus.i_core_valid = 1'b1;
                    bus.i_core_fmap  = ~res_of(cur);
                end
            end else if (pend > 0) begin
                chk("core_fmap_stable", bus.o_core_fmap, cur);
                pend--;
                if (pend == 0) begin
                    bus.i_core_valid = 1'b1;
                    bus.i_core_fmap  = res_of(cur);
                end
            end
            if (bus.o_ot_valid) begin
                seen = 1;
                chk("ot_cycle", cyc, NB*(lat+1)+1);
                exp_ot = res_q.pop_front();
                chk("ot_fmap", bus.o_ot_fmap, exp_ot);
                last_ot = exp_ot;
            end else begin
                chk("ot_fmap_hold", bus.o_ot_fmap, last_ot);
            end
        end
        if (!seen) fail_now("ot_valid_timeout");
        if (!hold) bus.i_in_valid = 1'b0;
    endtask

    initial begin
        bus.i_in_valid   = 1'b0;
        bus.i_in_fmap    = '0;
        bus.i_core_valid = 1'b0;
        bus.i_core_fmap  = '0;

        // Reset state
        #12;
        chk("rst_in_ready", bus.o_in_ready, 1'b0);
        chk("rst_busy", bus.o_busy, 1'b0);
        chk("rst_core_valid", bus.o_core_valid, 1'b0);
        chk("rst_ot_valid", bus.o_ot_valid, 1'b0);
        chk("rst_ot_fmap", bus.o_ot_fmap, '0);
        chk("rst_core_fmap", bus.o_core_fmap, '0);
        chk("rst_error", bus.o_error, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rel_in_ready", bus.o_in_ready, 1'b1);

        // Basic batch, L=3
        run_batch(mk_img($urandom), mk_img($urandom), 3, 0, 0);

        // Valid held high: accepts at 0 and 10 only
        run_batch(mk_img($urandom), mk_img($urandom), 3, 1, 0);
        run_batch(mk_img($urandom), mk_img($urandom), 3, 0, 0);

        // Spurious core result during ISSUE, short latency
        run_batch(mk_img($urandom), mk_img($urandom), 1, 0, 1);

        // Spurious core result in IDLE
        @(negedge clk);
        bus.i_core_valid = 1'b1;
        bus.i_core_fmap  = {(OT_W/8){8'hC3}};
        @(negedge clk);
        bus.i_core_valid = 1'b0;
        chk("idle_spur_busy", bus.o_busy, 1'b0);
        chk("idle_spur_ready", bus.o_in_ready, 1'b1);
        chk("idle_spur_ot", bus.o_ot_fmap, last_ot);

        // Soft reset in cycle 6 of a batch
        @(negedge clk);
        bus.i_in_valid = 1'b1;
        bus.i_in_fmap  = {mk_img(32'h1111_2222), mk_img(32'h3333_4444)};
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            bus.i_in_valid   = 1'b0;
            bus.i_core_valid = (c == 4);
            bus.i_core_fmap  = res_of(mk_img(32'h3333_4444));
            if (c == 6) i_soft_reset = 1'b1;
        end
        @(negedge clk);
        i_soft_reset     = 1'b0;
        bus.i_core_valid = 1'b0;
        chk("srst_busy", bus.o_busy, 1'b0);
        chk("srst_ready", bus.o_in_ready, 1'b1);
        chk("srst_ot_fmap", bus.o_ot_fmap, '0);
        chk("srst_core_fmap", bus.o_core_fmap, '0);
        last_ot = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("srst_no_ot_valid", bus.o_ot_valid, 1'b0);
        end
        run_batch(mk_img($urandom), mk_img($urandom), 2, 0, 0);

        // Asynchronous reset mid-WAIT, between edges
        @(negedge clk);
        bus.i_in_valid = 1'b1;
        bus.i_in_fmap  = {mk_img(32'hDEAD_BEEF), mk_img(32'hCAFE_F00D)};
        @(negedge clk);
        bus.i_in_valid = 1'b0;
        @(negedge clk);
        chk("arst_pre_busy", bus.o_busy, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_busy", bus.o_busy, 1'b0);
        chk("arst_ready", bus.o_in_ready, 1'b0);
        chk("arst_core_valid", bus.o_core_valid, 1'b0);
        chk("arst_core_fmap", bus.o_core_fmap, '0);
        chk("arst_ot_valid", bus.o_ot_valid, 1'b0);
        chk("arst_ot_fmap", bus.o_ot_fmap, '0);
        chk("arst_error", bus.o_error, 1'b0);
        #1;
        reset_n = 1'b1;
        last_ot = '0;
        @(negedge clk);
        chk("arst_rel_ready", bus.o_in_ready, 1'b1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("arst_no_ot_valid", bus.o_ot_valid, 1'b0);
        end
        run_batch(mk_img($urandom), mk_img($urandom), 3, 0, 0);

`ifdef CNN_SCHED_TIMEOUT_EN
        // Silent core: timeout after TMO WAIT cycles
        @(negedge clk);
        bus.i_in_valid = 1'b1;
        bus.i_in_fmap  = {mk_img(32'h0BAD_0BAD), mk_img(32'h0F0F_0F0F)};
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            bus.i_in_valid = 1'b0;
            chk("tmo_no_ot_valid", bus.o_ot_valid, 1'b0);
            chk("tmo_ot_hold", bus.o_ot_fmap, last_ot);
            if (c == 5) begin
                chk("tmo_err_before", bus.o_error, 1'b0);
                chk("tmo_busy_before", bus.o_busy, 1'b1);
            end
            if (c == 6) begin
                chk("tmo_err_set", bus.o_error, 1'b1);
                chk("tmo_idle", bus.o_busy, 1'b0);
            end
        end
        @(negedge clk);
        i_soft_reset = 1'b1;
        @(negedge clk);
        i_soft_reset = 1'b0;
        chk("tmo_err_cleared", bus.o_error, 1'b0);
        last_ot = '0;
`endif

        chk("queues_drained", img_q.size() + res_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
